// File: rtl/sim_phase_controller.sv
// Multi-phase raster simulation controller: runs NUM_PHASES full passes per game tick.
// Optional single-step debug mode is compiled in with SIM_DEBUG_STEP_EN.
module sim_phase_controller #(
    parameter int X_BITS     = 10,
    parameter int Y_BITS     = 9,
    parameter int PIXELS_X   = 640,
    parameter int PIXELS_Y   = 480,
    parameter int NUM_PHASES = 3,
    parameter int PHASE_BITS = 2,
    parameter int TICK_BITS  = 16
) (
    input  logic                  newLocClock,
    input  logic                  Reset,
    input  logic                  RUN,
    input  logic                  game_clock,
    input  logic                  pause,
    input  logic [X_BITS-1:0]     writeLoc_x,
    input  logic [Y_BITS-1:0]     writeLoc_y,
`ifdef SIM_DEBUG_STEP_EN
    input  logic                  debug_mode,
    input  logic                  KEY_STEP,
`endif
    output logic                  write_flag,
    output logic                  hold_locs,
    output logic [2:0]            sim_state,
    output logic [PHASE_BITS-1:0] phase,
    output logic                  pass_done,
    output logic                  tick_done,
    output logic [TICK_BITS-1:0]  tick_count,
    output logic                  overrun
);

    typedef enum logic [2:0] {
        INIT           = 3'd0,
        WRITE          = 3'd1,
        WAIT_TICK      = 3'd2,
        WAIT_STEP_DOWN = 3'd3,
        WAIT_STEP_UP   = 3'd4
    } state_t;

    localparam logic [PHASE_BITS-1:0] LAST_PHASE = PHASE_BITS'(NUM_PHASES - 1);
    localparam logic [X_BITS-1:0]     LAST_X     = X_BITS'(PIXELS_X - 1);
    localparam logic [Y_BITS-1:0]     LAST_Y     = Y_BITS'(PIXELS_Y - 1);

    state_t                  state_reg, state_next;
    logic [PHASE_BITS-1:0]   phase_reg, phase_next;
    logic [TICK_BITS-1:0]    tick_count_reg, tick_count_next;
    logic                    overrun_reg, overrun_next;
    logic                    tick_pending_reg, tick_pending_next;
    logic                    pass_done_reg, pass_done_next;
    logic                    tick_done_reg, tick_done_next;
    // [0],[1]: two-flop synchronizer; [2]: delayed copy for edge detection
    logic [2:0]              sync_reg;

    logic botright;
    logic game_edge;
    logic edge_taken;
    logic debug_active;
    logic consume;

`ifdef SIM_DEBUG_STEP_EN
    assign debug_active = debug_mode;
`else
    assign debug_active = 1'b0;
`endif

    assign botright   = (writeLoc_x == LAST_X) && (writeLoc_y == LAST_Y);
    assign game_edge  = sync_reg[1] && !sync_reg[2];
    assign edge_taken = game_edge && (state_reg != INIT) && !debug_active;

    always_comb begin
        state_next        = state_reg;
        phase_next        = phase_reg;
        tick_count_next   = tick_count_reg;
        overrun_next      = overrun_reg;
        tick_pending_next = tick_pending_reg;
        pass_done_next    = 1'b0;
        tick_done_next    = 1'b0;
        consume           = 1'b0;

        case (state_reg)
            INIT: begin
                if (botright) begin
                    state_next = WRITE;
                    phase_next = '0;
                end
            end
            WRITE: begin
                if (botright) begin
                    pass_done_next = 1'b1;
                    if (phase_reg == LAST_PHASE) begin
                        phase_next      = '0;
                        tick_count_next = tick_count_reg + 1'b1;
                        tick_done_next  = 1'b1;
                        state_next      = debug_active ? WAIT_STEP_DOWN : WAIT_TICK;
                    end else begin
                        phase_next = phase_reg + 1'b1;
                    end
                end
            end
            WAIT_TICK: begin
                if (tick_pending_reg && !pause) begin
                    state_next = WRITE;
                    consume    = 1'b1;
                end
            end
`ifdef SIM_DEBUG_STEP_EN
            WAIT_STEP_DOWN: begin
                if (!KEY_STEP) state_next = WAIT_STEP_UP;
            end
            WAIT_STEP_UP: begin
                if (KEY_STEP) state_next = WRITE;
            end
`endif
            default: state_next = INIT;
        endcase

        // An edge landing on the consume cycle re-arms the pending tick instead of overrunning
        if (consume) begin
            tick_pending_next = edge_taken;
        end else if (edge_taken) begin
            if (tick_pending_reg) overrun_next = 1'b1;
            else                  tick_pending_next = 1'b1;
        end
    end

    always_ff @(posedge newLocClock or posedge Reset) begin
        if (Reset) begin
            state_reg        <= INIT;
            phase_reg        <= '0;
            tick_count_reg   <= '0;
            overrun_reg      <= 1'b0;
            tick_pending_reg <= 1'b0;
            pass_done_reg    <= 1'b0;
            tick_done_reg    <= 1'b0;
            sync_reg         <= '0;
        end else if (!RUN) begin
            state_reg        <= INIT;
            phase_reg        <= '0;
            tick_count_reg   <= '0;
            overrun_reg      <= 1'b0;
            tick_pending_reg <= 1'b0;
            pass_done_reg    <= 1'b0;
            tick_done_reg    <= 1'b0;
            sync_reg         <= '0;
        end else begin
            state_reg        <= state_next;
            phase_reg        <= phase_next;
            tick_count_reg   <= tick_count_next;
            overrun_reg      <= overrun_next;
            tick_pending_reg <= tick_pending_next;
            pass_done_reg    <= pass_done_next;
            tick_done_reg    <= tick_done_next;
            sync_reg         <= {sync_reg[1:0], game_clock};
        end
    end

    assign write_flag = (state_reg == WRITE);
    assign hold_locs  = !((state_reg == INIT) || (state_reg == WRITE));
    assign sim_state  = state_reg;
    assign phase      = phase_reg;
    assign pass_done  = pass_done_reg;
    assign tick_done  = tick_done_reg;
    assign tick_count = tick_count_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_sim_phase_controller.sv
// Directed bench for sim_phase_controller on a 4x3 raster with three phases per tick.
// The step-mode scenario is included when SIM_DEBUG_STEP_EN is defined.
module tb_sim_phase_controller;

    localparam int X_BITS = 3;
    localparam int Y_BITS = 2;
    localparam int PX     = 4;
    localparam int PY     = 3;
    localparam int NP     = 3;
    localparam int PB     = 2;
    localparam int TB     = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic              game_clock;
    logic              pause;
    logic [X_BITS-1:0] loc_x;
    logic [Y_BITS-1:0] loc_y;
`ifdef SIM_DEBUG_STEP_EN
    logic              debug_mode;
    logic              key_step;
`endif
    logic              write_flag;
    logic              hold_locs;
    logic [2:0]        sim_state;
    logic [PB-1:0]     phase;
    logic              pass_done;
    logic              tick_done;
    logic [TB-1:0]     tick_count;
    logic              overrun;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sim_phase_controller #(
        .X_BITS(X_BITS), .Y_BITS(Y_BITS), .PIXELS_X(PX), .PIXELS_Y(PY),
        .NUM_PHASES(NP), .PHASE_BITS(PB), .TICK_BITS(TB)
    ) dut (
        .newLocClock(clk),
        .Reset(rst),
        .RUN(run),
        .game_clock(game_clock),
        .pause(pause),
        .writeLoc_x(loc_x),
        .writeLoc_y(loc_y),
`ifdef SIM_DEBUG_STEP_EN
        .debug_mode(debug_mode),
        .KEY_STEP(key_step),
`endif
        .write_flag(write_flag),
        .hold_locs(hold_locs),
        .sim_state(sim_state),
        .phase(phase),
        .pass_done(pass_done),
        .tick_done(tick_done),
        .tick_count(tick_count),
        .overrun(overrun)
    );

    // Free-running raster scanner, frozen while hold_locs is high
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            loc_x <= '0;
            loc_y <= '0;
        end else if (!hold_locs) begin
            if (loc_x == X_BITS'(PX - 1)) begin
                loc_x <= '0;
                loc_y <= (loc_y == Y_BITS'(PY - 1)) ? '0 : loc_y + 1'b1;
            end else begin
                loc_x <= loc_x + 1'b1;
            end
        end
    end

    task automatic wait_state(input logic [2:0] s, input int max_cycles);
        for (int n = 0; n < max_cycles && sim_state !== s; n++) @(negedge clk);
    endtask

    task automatic tick_pulse();
        game_clock = 1'b1;
        repeat (3) @(negedge clk);
        game_clock = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1; game_clock = 1'b0; pause = 1'b0;
`ifdef SIM_DEBUG_STEP_EN
        debug_mode = 1'b0; key_step = 1'b1;
`endif
        repeat (2) @(negedge clk);
        checks++; if (sim_state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", sim_state); else passed++;
        checks++; if (phase !== 2'd0) $display("FAIL reset_phase: got %0d expected 0", phase); else passed++;
        checks++; if (tick_count !== 16'd0) $display("FAIL reset_tick_count: got %0d expected 0", tick_count); else passed++;
        checks++; if ({overrun, pass_done, tick_done} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {overrun, pass_done, tick_done}); else passed++;
        checks++; if ({hold_locs, write_flag} !== 2'b00) $display("FAIL reset_hold_write: got %b expected 00", {hold_locs, write_flag}); else passed++;
        $display("reset: state=%0d phase=%0d tick_count=%0d", sim_state, phase, tick_count);
    endtask

    task automatic test_multi_phase();
        int n_init = 0, n_write = 0, phase_err = 0, n_pd = 0, n_td = 0, n_wf = 0;
        rst = 1'b0;
        while (sim_state === 3'd0 && n_init < 100) begin
            n_init++;
            @(negedge clk);
        end
        while (sim_state === 3'd1 && n_write < 100) begin
            if (phase !== PB'(n_write / 12)) phase_err++;
            n_pd += int'(pass_done);
            n_td += int'(tick_done);
            n_wf += int'(write_flag);
            n_write++;
            @(negedge clk);
        end
        n_pd += int'(pass_done);
        n_td += int'(tick_done);
        checks++; if (n_init !== 12) $display("FAIL init_cycles: got %0d expected 12", n_init); else passed++;
        checks++; if (n_write !== 36) $display("FAIL write_cycles: got %0d expected 36", n_write); else passed++;
        checks++; if (phase_err !== 0) $display("FAIL phase_sequence: got %0d wrong samples expected 0", phase_err); else passed++;
        checks++; if (n_wf !== 36) $display("FAIL write_flag_count: got %0d expected 36", n_wf); else passed++;
        checks++; if (n_pd !== 3) $display("FAIL pass_done_count: got %0d expected 3", n_pd); else passed++;
        checks++; if (n_td !== 1) $display("FAIL tick_done_count: got %0d expected 1", n_td); else passed++;
        checks++; if (sim_state !== 3'd2) $display("FAIL tick_end_state: got %0d expected 2", sim_state); else passed++;
        checks++; if (tick_count !== 16'd1) $display("FAIL tick_count_1: got %0d expected 1", tick_count); else passed++;
        checks++; if ({hold_locs, write_flag} !== 2'b10) $display("FAIL wait_hold_write: got %b expected 10", {hold_locs, write_flag}); else passed++;
        checks++; if (phase !== 2'd0) $display("FAIL wait_phase: got %0d expected 0", phase); else passed++;
        @(negedge clk);
        checks++; if ({pass_done, tick_done} !== 2'b00) $display("FAIL pulse_width: got %b expected 00", {pass_done, tick_done}); else passed++;
        $display("multi_phase: init=%0d write=%0d pass_done=%0d tick_done=%0d tick_count=%0d", n_init, n_write, n_pd, n_td, tick_count);
    endtask

    task automatic test_tick_release();
        int stray = 0;
        game_clock = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (sim_state !== 3'd2) $display("FAIL pre_release: got %0d expected 2", sim_state); else passed++;
        @(negedge clk);
        checks++; if (sim_state !== 3'd1) $display("FAIL release_state: got %0d expected 1", sim_state); else passed++;
        checks++; if (phase !== 2'd0) $display("FAIL release_phase: got %0d expected 0", phase); else passed++;
        game_clock = 1'b0;
        wait_state(3'd2, 60);
        checks++; if (tick_count !== 16'd2) $display("FAIL tick_count_2: got %0d expected 2", tick_count); else passed++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sim_state !== 3'd2) stray++;
        end
        checks++; if (stray !== 0) $display("FAIL pending_cleared: got %0d non-wait samples expected 0", stray); else passed++;
        $display("tick_release: tick_count=%0d stray=%0d", tick_count, stray);
    endtask

    task automatic test_pause();
        int stray = 0;
        pause = 1'b1;
        tick_pulse();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sim_state !== 3'd2) stray++;
        end
        checks++; if (stray !== 0) $display("FAIL pause_hold: got %0d non-wait samples expected 0", stray); else passed++;
        pause = 1'b0;
        @(negedge clk);
        checks++; if (sim_state !== 3'd1) $display("FAIL unpause_release: got %0d expected 1", sim_state); else passed++;
        wait_state(3'd2, 60);
        checks++; if (tick_count !== 16'd3) $display("FAIL tick_count_3: got %0d expected 3", tick_count); else passed++;
        $display("pause: stray=%0d tick_count=%0d", stray, tick_count);
    endtask

    task automatic test_overrun();
        int stray = 0;
        tick_pulse();
        checks++; if (sim_state !== 3'd1) $display("FAIL ovr_release: got %0d expected 1", sim_state); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL ovr_single_edge: got %0d expected 0", overrun); else passed++;
        tick_pulse();
        tick_pulse();
        checks++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %0d expected 1", overrun); else passed++;
        wait_state(3'd2, 60);
        checks++; if (tick_count !== 16'd4) $display("FAIL tick_count_4: got %0d expected 4", tick_count); else passed++;
        @(negedge clk);
        checks++; if (sim_state !== 3'd1) $display("FAIL ovr_queued_release: got %0d expected 1", sim_state); else passed++;
        wait_state(3'd2, 60);
        checks++; if (tick_count !== 16'd5) $display("FAIL tick_count_5: got %0d expected 5", tick_count); else passed++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sim_state !== 3'd2) stray++;
        end
        checks++; if (stray !== 0) $display("FAIL ovr_single_release: got %0d non-wait samples expected 0", stray); else passed++;
        checks++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %0d expected 1", overrun); else passed++;
        $display("overrun: overrun=%0d tick_count=%0d stray=%0d", overrun, tick_count, stray);
    endtask

    task automatic test_async_reset_mid_write();
        tick_pulse();
        for (int n = 0; n < 60 && phase !== 2'd1; n++) @(negedge clk);
        checks++; if ({sim_state, phase} !== {3'd1, 2'd1}) $display("FAIL mid_write_reached: got state %0d phase %0d expected 1/1", sim_state, phase); else passed++;
        #2 rst = 1'b1;
        #1;
        checks++; if (sim_state !== 3'd0) $display("FAIL async_rst_state: got %0d expected 0", sim_state); else passed++;
        checks++; if (phase !== 2'd0) $display("FAIL async_rst_phase: got %0d expected 0", phase); else passed++;
        checks++; if (tick_count !== 16'd0) $display("FAIL async_rst_tick_count: got %0d expected 0", tick_count); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL async_rst_overrun: got %0d expected 0", overrun); else passed++;
        @(negedge clk);
        rst = 1'b0;
        $display("async_reset: state=%0d phase=%0d tick_count=%0d overrun=%0d", sim_state, phase, tick_count, overrun);
    endtask

    task automatic test_run_low();
        int stray = 0;
        tick_pulse();
        wait_state(3'd1, 30);
        wait_state(3'd2, 60);
        checks++; if (tick_count !== 16'd1) $display("FAIL run_tick_count_1: got %0d expected 1", tick_count); else passed++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sim_state !== 3'd2) stray++;
        end
        checks++; if (stray !== 0) $display("FAIL init_edge_discarded: got %0d non-wait samples expected 0", stray); else passed++;
        tick_pulse();
        for (int n = 0; n < 60 && phase !== 2'd1; n++) @(negedge clk);
        run = 1'b0;
        #1;
        checks++; if ({sim_state, phase} !== {3'd1, 2'd1}) $display("FAIL run_low_sync: got state %0d phase %0d expected 1/1", sim_state, phase); else passed++;
        @(negedge clk);
        checks++; if ({sim_state, phase} !== {3'd0, 2'd0}) $display("FAIL run_low_init: got state %0d phase %0d expected 0/0", sim_state, phase); else passed++;
        checks++; if (tick_count !== 16'd0) $display("FAIL run_low_tick_count: got %0d expected 0", tick_count); else passed++;
        run = 1'b1;
        $display("run_low: state=%0d phase=%0d tick_count=%0d", sim_state, phase, tick_count);
    endtask

`ifdef SIM_DEBUG_STEP_EN
    task automatic test_debug_step();
        int stray = 0;
        debug_mode = 1'b1;
        key_step = 1'b1;
        wait_state(3'd1, 30);
        wait_state(3'd3, 60);
        checks++; if (sim_state !== 3'd3) $display("FAIL dbg_step_down: got %0d expected 3", sim_state); else passed++;
        checks++; if (hold_locs !== 1'b1) $display("FAIL dbg_hold: got %0d expected 1", hold_locs); else passed++;
        tick_pulse();
        tick_pulse();
        checks++; if ({sim_state, overrun} !== {3'd3, 1'b0}) $display("FAIL dbg_edges_ignored: got state %0d overrun %0d expected 3/0", sim_state, overrun); else passed++;
        key_step = 1'b0;
        @(negedge clk);
        checks++; if (sim_state !== 3'd4) $display("FAIL dbg_step_up: got %0d expected 4", sim_state); else passed++;
        key_step = 1'b1;
        @(negedge clk);
        checks++; if (sim_state !== 3'd1) $display("FAIL dbg_step_write: got %0d expected 1", sim_state); else passed++;
        debug_mode = 1'b0;
        wait_state(3'd2, 60);
        checks++; if (tick_count !== 16'd2) $display("FAIL dbg_tick_count: got %0d expected 2", tick_count); else passed++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sim_state !== 3'd2) stray++;
        end
        checks++; if (stray !== 0) $display("FAIL dbg_no_pending: got %0d non-wait samples expected 0", stray); else passed++;
        $display("debug_step: tick_count=%0d stray=%0d", tick_count, stray);
    endtask
`endif

    initial begin
        test_reset();
        test_multi_phase();
        test_tick_release();
        test_pause();
        test_overrun();
        test_async_reset_mid_write();
        test_run_low();
`ifdef SIM_DEBUG_STEP_EN
        test_debug_step();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sim_phase_controller.md
Name: sim_phase_controller

Overview:
- Parametrised successor to the single-pass simulation state controller.
- Sequences NUM_PHASES full raster passes (e.g. sense, move, pheromone decay) per game tick. Gates location/envCache cycling with hold_locs.
- Detects game_clock rising edges internally, counts ticks, supports pause and flags tick overruns.
- Sits between the location scanner (writeLoc_x/y source) and the per-pixel simulation write logic.

Parameters:
- X_BITS, 10, width of writeLoc_x
- Y_BITS, 9, width of writeLoc_y
- PIXELS_X, 640, columns per pass; last column is PIXELS_X-1
- PIXELS_Y, 480, rows per pass; last row is PIXELS_Y-1
- NUM_PHASES, 3, passes per tick; must be at least 1
- PHASE_BITS, 2, width of phase; must satisfy 2^PHASE_BITS >= NUM_PHASES
- TICK_BITS, 16, width of tick_count

Ports:
- newLocClock  in  1  system clock; one location per cycle
- Reset  in  1  asynchronous, active-high
- RUN  in  1  synchronous enable; low forces INIT
- game_clock  in  1  asynchronous tick source
- pause  in  1  level; holds in WAIT_TICK while high
- writeLoc_x  in  X_BITS  current scan column
- writeLoc_y  in  Y_BITS  current scan row
- write_flag  out  1  high in WRITE
- hold_locs  out  1  low in INIT/WRITE, high otherwise
- sim_state  out  3  encoded state
- phase  out  PHASE_BITS  current pass index
- pass_done  out  1  one-cycle pulse at the end of each WRITE pass
- tick_done  out  1  one-cycle pulse when the final phase completes
- tick_count  out  TICK_BITS  completed ticks; wraps
- overrun  out  1  sticky; tick edge lost

Behaviour:
- State encoding: INIT=0, WRITE=1, WAIT_TICK=2, WAIT_STEP_DOWN=3, WAIT_STEP_UP=4.
- Reset (async): state INIT, phase 0, tick_count 0, overrun 0, tick_pending 0, synchronizer flops 0, pass_done 0, tick_done 0.
- RUN=0 at a clock edge: same values as reset, applied synchronously.
- botright = (writeLoc_x==PIXELS_X-1) && (writeLoc_y==PIXELS_Y-1).
- INIT: hold_locs=0, write_flag=0. On botright -> WRITE with phase 0 (one warm-up pass).
- WRITE on botright, phase < NUM_PHASES-1: phase+1, stay WRITE, pass_done=1.
- WRITE on botright, last phase: phase<=0, tick_count+1 (wraps at 2^TICK_BITS), pass_done=1, tick_done=1, -> WAIT_TICK.
- WAIT_TICK: hold_locs=1. If tick_pending && !pause -> WRITE, clearing tick_pending in the same cycle.
- Pause is sampled only in WAIT_TICK. A pass already in progress always completes.
- Edge detect: game_clock goes through a 2-flop synchronizer; edge = sync && !sync_d. Edge to tick_pending takes 3 cycles.
- Edge with tick_pending=0: set tick_pending (any state except INIT).
- Edge with tick_pending=1: set overrun; the pending tick is kept and no second tick is queued.
- Edge coinciding with the WAIT_TICK->WRITE consume: tick_pending stays 1, no overrun.
- Edges arriving in INIT are discarded.
- pass_done and tick_done are registered, valid the cycle after botright. Other outputs are combinational from registers.
- NUM_PHASES=1: every pass ends a tick.

Optional Feature:
- Macro: SIM_DEBUG_STEP_EN.
- With macro: adds ports debug_mode (in 1) and KEY_STEP (in 1, active-low).
- If debug_mode=1, the final-phase botright goes -> WAIT_STEP_DOWN. KEY_STEP=0 -> WAIT_STEP_UP. KEY_STEP=1 -> WRITE.
- In debug mode game_clock edges neither set tick_pending nor overrun. Pause is ignored in step states. hold_locs=1 in both step states.
- Without macro: ports absent, states 3/4 unreachable, behaviour as debug_mode=0.

Test Plan:
- Multi-phase sequencing: PIXELS_X=4, PIXELS_Y=3, NUM_PHASES=3, RUN=1, scanner free-running -> INIT for 12 cycles, then 36 WRITE cycles with phase 0,1,2; pass_done x3; tick_done once; tick_count=1; state 2; hold_locs=1.
- Tick release: in WAIT_TICK, raise game_clock -> WRITE 3-4 cycles later, phase 0, tick_pending cleared.
- Pause: pause=1 in WAIT_TICK with an edge given -> stays state 2 indefinitely; pause=0 -> WRITE next cycle.
- Overrun: two game_clock rising edges during one 36-cycle tick -> overrun=1 (sticky); exactly one release from WAIT_TICK; Reset pulse -> overrun=0.
- Reset/RUN mid-WRITE: async Reset at phase 1 -> immediately INIT, phase 0, tick_count 0. RUN=0 mid-pass -> INIT at next edge.
- With SIM_DEBUG_STEP_EN, debug_mode=1: tick ends -> state 3; game_clock edges ignored; KEY_STEP 0 -> state 4; 1 -> WRITE.
